axil_fifo_reader: RTL

AXIL_FIFO_READER -- requirements
Module: axil_fifo_reader

---
 rtl/axil_fifo_reader_if.sv | 23 ++
 rtl/axil_fifo_reader.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/axil_fifo_reader_if.sv
// AXI-Lite read-only channel bundle (AR + R) shared by the FIFO reader and its master.
interface axil_fifo_reader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_fifo_reader.sv
// AXI-Lite read slave that pops a synchronous FIFO on DATA reads and exposes
// FIFO status plus pop/error counters; one read transaction in flight at a time.
module axil_fifo_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axil_fifo_reader_if.slave     s_axil,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_full
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e                state_q, state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [31:0]           pop_count_q, pop_count_d;
  logic [15:0]           err_count_q, err_count_d;

  logic                  ar_hs_s;
  logic                  r_hs_s;
  logic                  misaligned_s;
  logic [1:0]            reg_sel_s;

  assign ar_hs_s      = s_axil.arvalid & arready_q;
  assign r_hs_s       = rvalid_q & s_axil.rready;
  assign misaligned_s = (s_axil.araddr[1:0] != 2'b00);
  assign reg_sel_s    = s_axil.araddr[3:2];

  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ar_hs_s) begin
          if (!misaligned_s && (reg_sel_s == 2'b00)) begin
            state_d = POP;
          end else begin
            state_d = RESP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      POP: begin
        if (!fifo_empty) begin
          state_d = CAPT;
        end else begin
          state_d = RESP;
        end
      end
      CAPT: state_d = RESP;
      RESP: begin
        if (r_hs_s) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values; arready/rvalid track the upcoming state so they are registered.
  always_comb begin
    fifo_rd_en  = 1'b0;
    arready_d   = (state_d == IDLE);
    rvalid_d    = (state_d == RESP);
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    pop_count_d = pop_count_q;
    err_count_d = err_count_q;
    case (state_q)
      IDLE: begin
        if (ar_hs_s) begin
          if (misaligned_s) begin
            rdata_d = {DATA_WIDTH{1'b0}};
            rresp_d = RESP_SLVERR;
          end else begin
            rresp_d = RESP_OKAY;
            case (reg_sel_s)
              2'b01:   rdata_d = DATA_WIDTH'({30'd0, fifo_full, fifo_empty});
              2'b10:   rdata_d = DATA_WIDTH'(pop_count_q);
              2'b11:   rdata_d = DATA_WIDTH'({16'd0, err_count_q});
              default: rdata_d = rdata_q;
            endcase
          end
        end else begin
          rdata_d = rdata_q;
        end
      end
      POP: begin
        if (!fifo_empty) begin
          fifo_rd_en  = 1'b1;
          pop_count_d = pop_count_q + 32'd1;
        end else begin
          rdata_d = {DATA_WIDTH{1'b0}};
          rresp_d = RESP_SLVERR;
          if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end else begin
            err_count_d = err_count_q;
          end
        end
      end
      CAPT: begin
        rdata_d = fifo_rd_data;
        rresp_d = RESP_OKAY;
      end
      RESP: begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
      end
      default: begin
        fifo_rd_en = 1'b0;
      end
    endcase
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= {DATA_WIDTH{1'b0}};
      rresp_q     <= 2'b00;
      pop_count_q <= 32'd0;
      err_count_q <= 16'd0;
    end else begin
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      pop_count_q <= pop_count_d;
      err_count_q <= err_count_d;
    end
  end

endmodule
